mul_div_unit: RTL

- Multi-cycle signed multiply/divide unit that sits directly downstream of the bus multiplexer.
- Operand A is taken from the Y register; operand B is taken from the bus output in the same cycle as start.
- The 2*WIDTH result is written to the Z register pair: zhi and zlo, which feed back into the bus multiplexer.
- Runs iteratively under a start/busy/done handshake from the control unit.

---
 rtl/mul_div_unit_if.sv | 37 +++
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between control unit and mul_div_unit
//
// Purpose: groups the start/busy/done handshake, the operands and the
// Z-register result outputs of the multiply/divide unit.
// Signals:
//   start        request, sampled only while the unit is idle
//   op           0 = signed multiply, 1 = signed divide
//   a            operand A (Y register): multiplicand or dividend
//   b            operand B (bus): multiplier or divisor
//   busy         high from the accepting edge until done
//   done         one-cycle completion pulse
//   div_by_zero  set with done when a divide had a zero divisor
//   zhi / zlo    product high/low, or remainder/quotient
// Modports: master = control unit side, slave = mul_div_unit side.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] zhi;
  logic [WIDTH-1:0] zlo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, zhi, zlo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, zhi, zlo
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative signed multiply (radix-2 Booth) / restoring divide unit
//
// Purpose: computes a*b (2*WIDTH-bit product) or a/b (quotient truncated toward
// zero, remainder signed like the dividend) over WIDTH iteration cycles and
// writes the result to the Z register pair zhi/zlo.
// Ports:
//   clk    system clock, rising edge
//   clr_n  asynchronous active-low reset
//   bus    mul_div_unit_if.slave: start/op/a/b in, busy/done/div_by_zero/zhi/zlo out
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           clr_n,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t           state;
  logic             opr;
  logic [WIDTH-1:0] md;    // mul: multiplicand; div: |divisor| after LOAD
  logic [WIDTH-1:0] lo;    // mul: multiplier / product low; div: quotient
  logic [WIDTH:0]   acc;   // mul: product high (one guard bit); div: remainder
  logic             xb;    // Booth extra bit to the right of lo
  logic             qs;    // quotient sign
  logic             rs;    // remainder sign (dividend sign)
  logic             dz;    // divide-by-zero result pending for done
  logic [CW-1:0]    cnt;

  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] zhi_r;
  logic [WIDTH-1:0] zlo_r;

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.zhi         = zhi_r;
  assign bus.zlo         = zlo_r;

  logic [WIDTH:0] md_x;
  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    // The guard bit on the high half keeps -(-2^(W-1)) representable.
    md_x = {md[WIDTH-1], md};
    case ({lo[0], xb})
      2'b01:   booth_sum = acc + md_x;
      2'b10:   booth_sum = acc - md_x;
      default: booth_sum = acc;
    endcase
    rem_sh = {acc[WIDTH-1:0], lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, md};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      opr    <= 1'b0;
      md     <= '0;
      lo     <= '0;
      acc    <= '0;
      xb     <= 1'b0;
      qs     <= 1'b0;
      rs     <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      zhi_r  <= '0;
      zlo_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          // A start overlapping the done pulse is dropped, not queued.
          if (bus.start && !done_r) begin
            md     <= bus.a;
            lo     <= bus.b;
            opr    <= bus.op;
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          cnt <= CW'(WIDTH - 1);
          acc <= '0;
          xb  <= 1'b0;
          dz  <= 1'b0;
          if (!opr) begin
            state <= CALC;
          end else begin
            // Swap roles: md becomes |divisor|, lo becomes |dividend|.
            md <= lo[WIDTH-1] ? -lo : lo;
            lo <= md[WIDTH-1] ? -md : md;
            qs <= md[WIDTH-1] ^ lo[WIDTH-1];
            rs <= md[WIDTH-1];
            if (lo == '0) begin
              zhi_r <= md;
              zlo_r <= '1;
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!opr) begin
            acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lo  <= {booth_sum[0], lo[WIDTH-1:1]};
            xb  <= lo[0];
          end else begin
            lo  <= {lo[WIDTH-2:0], ~trial[WIDTH]};
            acc <= trial[WIDTH] ? rem_sh : trial;
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (!opr) begin
            zhi_r <= acc[WIDTH-1:0];
            zlo_r <= lo;
          end else begin
            zhi_r <= rs ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            zlo_r <= qs ? -lo : lo;
          end
          state <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          dbz_r  <= dz;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
